// File: rtl/timer_seq_pkg.sv
// Shared types and default widths for the timer sequencer.
// The state encoding is private to the sequencer; widths are defaults for instantiation.
package timer_seq_pkg;

  localparam int N_DEF  = 4;
  localparam int PW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_zero_load(
    input logic [31:0] val
  );
    return (val == 32'd0);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into a tick every div+1 cycles while not frozen.
// clr restarts the phase so the first tick lands div+1 cycles later.
module tick_prescaler
  import timer_seq_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          freeze,
  input  logic [PW-1:0] div,
  output logic          tick
);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          wrap;

  // >= keeps the phase bounded even if div shrinks under us
  assign wrap = (pre_q >= div);
  assign tick = ~clr & ~freeze & wrap;

  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (!freeze) begin
      pre_d = wrap ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// Programmable down-count timer: one-shot or auto-reload, with hold and stop.
// Optional tick prescaler enabled by defining TIMER_SEQ_PRESCALE_EN.
module timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          hold,
  input  logic          periodic,
  input  logic [N-1:0]  load_val,
`ifdef TIMER_SEQ_PRESCALE_EN
  input  logic [PW-1:0] prescale_div,
`endif
  output logic [N-1:0]  cnt,
  output logic          busy,
  output logic          tc_pulse,
  output logic          done
);

  state_t       state_q;
  state_t       state_d;
  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;
  logic [N-1:0] reload_q;
  logic [N-1:0] reload_d;
  logic         mode_q;
  logic         mode_d;
  logic         tc_q;
  logic         tc_d;
  logic         done_q;
  logic         done_d;
  logic         busy_q;
  logic         busy_d;
  logic         tick;
  logic         step;

`ifdef TIMER_SEQ_PRESCALE_EN
  logic [PW-1:0] div_q;
  logic [PW-1:0] div_d;

  always_comb begin
    div_d = div_q;
    if (start && !stop) begin
      div_d = prescale_div;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  tick_prescaler #(
    .PW (PW)
  ) u_pre (
    .clk    (clk),
    .rst    (rst),
    .clr    (start | stop),
    .freeze (hold | (state_q != RUN)),
    .div    (div_q),
    .tick   (tick)
  );
`else
  logic unused_cfg;

  // without the prescaler every cycle is a tick
  assign unused_cfg = (PW > 0);
  assign tick       = 1'b1;
`endif

  assign step = (state_q == RUN) & ~hold & tick;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    done_d   = done_q;
    busy_d   = busy_q;
    if (stop) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else if (start) begin
      reload_d = load_val;
      mode_d   = periodic;
      cnt_d    = load_val;
      done_d   = 1'b0;
      state_d  = RUN;
      busy_d   = 1'b1;
    end else if (step) begin
      unique case (1'b1)
        (cnt_q > N'(1)): begin
          cnt_d = cnt_q - N'(1);
        end
        (cnt_q == N'(1)): begin
          cnt_d = '0;
          tc_d  = 1'b1;
          if (!mode_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
        (cnt_q == '0): begin
          if (mode_q) begin
            cnt_d = reload_q;
            tc_d  = (reload_q == '0);
          end else begin
            tc_d    = 1'b1;
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign cnt      = cnt_q;
  assign busy     = busy_q;
  assign tc_pulse = tc_q;
  assign done     = done_q;

endmodule
